// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, execute-side outputs and the stall/bubble status.
// The master modport is the surrounding pipeline; the slave modport is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTL_W  = 9,
  parameter int CNT_W  = 16
);
  logic              valid_in;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] imm_in;
  logic [DATA_W-1:0] pc_in;
  logic [REG_AW-1:0] rs_in;
  logic [REG_AW-1:0] rt_in;
  logic [REG_AW-1:0] rd_in;
  logic [CTL_W-1:0]  ctl_in;
  logic              hold;
  logic              flush;

  logic              valid_out;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [DATA_W-1:0] imm_out;
  logic [DATA_W-1:0] pc_out;
  logic [REG_AW-1:0] rs_out;
  logic [REG_AW-1:0] rt_out;
  logic [REG_AW-1:0] rd_out;
  logic [CTL_W-1:0]  ctl_out;
  logic              stall_out;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output valid_in, a_in, b_in, imm_in, pc_in, rs_in, rt_in, rd_in, ctl_in, hold, flush,
    input  valid_out, a_out, b_out, imm_out, pc_out, rs_out, rt_out, rd_out, ctl_out,
           stall_out, bubble_cnt
  );

  modport slave (
    input  valid_in, a_in, b_in, imm_in, pc_in, rs_in, rt_in, rd_in, ctl_in, hold, flush,
    output valid_out, a_out, b_out, imm_out, pc_out, rs_out, rt_out, rd_out, ctl_out,
           stall_out, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, downstream hold,
// branch flush and a saturating count of injected load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTL_W  = 9,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);
  // Control word is {regwrite,memtoreg,branch,memread,memwrite,regdst,aluop[1:0],alusrc}
  localparam int MEMREAD_BIT = CTL_W - 4;

  logic              valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] pc_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [CTL_W-1:0]  ctl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_use;

  // A load sitting in EX whose destination feeds either ID source; $0 never counts
  always_comb begin
    load_use = valid_q & ctl_q[MEMREAD_BIT] & bus.valid_in & (rt_q != '0) &
               ((rt_q == bus.rs_in) | (rt_q == bus.rt_in));
  end

  // Pipeline register update: flush beats hold, hold beats the bubble, bubble beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctl_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
    end else if (!bus.hold) begin
      if (load_use) begin
        valid_q <= 1'b0;
        ctl_q   <= '0;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        valid_q <= bus.valid_in;
        a_q     <= bus.a_in;
        b_q     <= bus.b_in;
        imm_q   <= bus.imm_in;
        pc_q    <= bus.pc_in;
        rs_q    <= bus.rs_in;
        rt_q    <= bus.rt_in;
        rd_q    <= bus.rd_in;
        ctl_q   <= bus.valid_in ? bus.ctl_in : '0;
      end
    end
  end

  // Drive the execute-side outputs and the upstream freeze request
  always_comb begin
    bus.valid_out  = valid_q;
    bus.a_out      = a_q;
    bus.b_out      = b_q;
    bus.imm_out    = imm_q;
    bus.pc_out     = pc_q;
    bus.rs_out     = rs_q;
    bus.rt_out     = rt_q;
    bus.rd_out     = rd_q;
    bus.ctl_out    = ctl_q;
    bus.bubble_cnt = cnt_q;
    bus.stall_out  = bus.hold | load_use;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. A second instance with a 3-bit bubble
// counter receives the same stimulus so that saturation is reachable quickly.
module tb_id_ex_stage;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   exp_cnt;

  localparam logic [8:0] CTL_R  = 9'h10C;
  localparam logic [8:0] CTL_LW = 9'h1A1;
  localparam logic [8:0] CTL_A  = 9'h1C1;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTL_W(9), .CNT_W(16)) m_if ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTL_W(9), .CNT_W(3))  s_if ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTL_W(9), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave)
  );
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTL_W(9), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both instances identically; b/imm/pc are derived from a so they can be checked too
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [8:0] ctl, input logic h, input logic f);
    m_if.valid_in = v;  s_if.valid_in = v;
    m_if.a_in = a;      s_if.a_in = a;
    m_if.b_in = ~a;     s_if.b_in = ~a;
    m_if.imm_in = a + 32'd1; s_if.imm_in = a + 32'd1;
    m_if.pc_in = a + 32'd4;  s_if.pc_in = a + 32'd4;
    m_if.rs_in = rs;    s_if.rs_in = rs;
    m_if.rt_in = rt;    s_if.rt_in = rt;
    m_if.rd_in = rd;    s_if.rd_in = rd;
    m_if.ctl_in = ctl;  s_if.ctl_in = ctl;
    m_if.hold = h;      s_if.hold = h;
    m_if.flush = f;     s_if.flush = f;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h0, 1'b0, 1'b0);
    #12 rst_n = 1'b1;

    // Reset: load real values, then drop rst_n mid-cycle and expect immediate clearing
    applyStimulus(1'b1, 32'hAAAA, 5'd1, 5'd2, 5'd3, CTL_A, 1'b0, 1'b0);
    tick();
    checkOutput("pre_rst_a", 64'(m_if.a_out), 64'hAAAA);
    checkOutput("pre_rst_valid", 64'(m_if.valid_out), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(m_if.valid_out), 64'h0);
    checkOutput("rst_a", 64'(m_if.a_out), 64'h0);
    checkOutput("rst_b", 64'(m_if.b_out), 64'h0);
    checkOutput("rst_pc", 64'(m_if.pc_out), 64'h0);
    checkOutput("rst_rd", 64'(m_if.rd_out), 64'h0);
    checkOutput("rst_ctl", 64'(m_if.ctl_out), 64'h0);
    checkOutput("rst_stall", 64'(m_if.stall_out), 64'h0);
    tick();
    checkOutput("rst_held_a", 64'(m_if.a_out), 64'h0);
    #2 rst_n = 1'b1;

    // Plain flow: one-cycle capture of every field
    applyStimulus(1'b1, 32'h1234, 5'd3, 5'd4, 5'd7, CTL_A, 1'b0, 1'b0);
    #1 checkOutput("flow_stall_pre", 64'(m_if.stall_out), 64'h0);
    tick();
    checkOutput("flow_a", 64'(m_if.a_out), 64'h1234);
    checkOutput("flow_b", 64'(m_if.b_out), 64'hFFFF_EDCB);
    checkOutput("flow_imm", 64'(m_if.imm_out), 64'h1235);
    checkOutput("flow_pc", 64'(m_if.pc_out), 64'h1238);
    checkOutput("flow_rs", 64'(m_if.rs_out), 64'd3);
    checkOutput("flow_rt", 64'(m_if.rt_out), 64'd4);
    checkOutput("flow_rd", 64'(m_if.rd_out), 64'd7);
    checkOutput("flow_ctl", 64'(m_if.ctl_out), 64'h1C1);
    checkOutput("flow_valid", 64'(m_if.valid_out), 64'h1);
    checkOutput("flow_stall", 64'(m_if.stall_out), 64'h0);

    // Load-use on rs: one bubble, datapath held, then the dependent instruction enters
    applyStimulus(1'b1, 32'h5000, 5'd1, 5'd5, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hDEAD, 5'd5, 5'd6, 5'd8, CTL_R, 1'b0, 1'b0);
    #1 checkOutput("lu_rs_stall", 64'(m_if.stall_out), 64'h1);
    tick();
    exp_cnt++;
    checkOutput("lu_bubble_valid", 64'(m_if.valid_out), 64'h0);
    checkOutput("lu_bubble_ctl", 64'(m_if.ctl_out), 64'h0);
    checkOutput("lu_bubble_cnt", 64'(m_if.bubble_cnt), 64'd1);
    checkOutput("lu_held_a", 64'(m_if.a_out), 64'h5000);
    checkOutput("lu_stall_drop", 64'(m_if.stall_out), 64'h0);
    tick();
    checkOutput("lu_capture_a", 64'(m_if.a_out), 64'hDEAD);
    checkOutput("lu_capture_ctl", 64'(m_if.ctl_out), 64'h10C);
    checkOutput("lu_capture_valid", 64'(m_if.valid_out), 64'h1);

    // Load-use on rt
    applyStimulus(1'b1, 32'h5100, 5'd1, 5'd9, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hBEEF, 5'd2, 5'd9, 5'd10, CTL_R, 1'b0, 1'b0);
    #1 checkOutput("lu_rt_stall", 64'(m_if.stall_out), 64'h1);
    tick();
    exp_cnt++;
    checkOutput("lu_rt_cnt", 64'(m_if.bubble_cnt), 64'(exp_cnt));
    tick();
    checkOutput("lu_rt_capture_a", 64'(m_if.a_out), 64'hBEEF);

    // Load into $0 never creates a hazard
    applyStimulus(1'b1, 32'h5200, 5'd1, 5'd0, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0C0C, 5'd0, 5'd0, 5'd11, CTL_R, 1'b0, 1'b0);
    #1 checkOutput("zero_stall", 64'(m_if.stall_out), 64'h0);
    tick();
    checkOutput("zero_valid", 64'(m_if.valid_out), 64'h1);
    checkOutput("zero_a", 64'(m_if.a_out), 64'h0C0C);
    checkOutput("zero_cnt", 64'(m_if.bubble_cnt), 64'(exp_cnt));

    // Invalid ID slot does not hazard, and its control is zeroed on capture
    applyStimulus(1'b1, 32'h5300, 5'd1, 5'd5, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0D0D, 5'd5, 5'd5, 5'd12, CTL_R, 1'b0, 1'b0);
    #1 checkOutput("inv_stall", 64'(m_if.stall_out), 64'h0);
    tick();
    checkOutput("inv_valid", 64'(m_if.valid_out), 64'h0);
    checkOutput("inv_ctl", 64'(m_if.ctl_out), 64'h0);
    checkOutput("inv_a", 64'(m_if.a_out), 64'h0D0D);

    // Hold for three cycles with changing inputs
    applyStimulus(1'b1, 32'h7777, 5'd1, 5'd2, 5'd3, CTL_R, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 5'(i + 4), 5'(i + 6), 5'(i + 8), CTL_A, 1'b1, 1'b0);
      #1 checkOutput("hold_stall", 64'(m_if.stall_out), 64'h1);
      tick();
      checkOutput("hold_a", 64'(m_if.a_out), 64'h7777);
      checkOutput("hold_ctl", 64'(m_if.ctl_out), 64'h10C);
    end
    applyStimulus(1'b1, 32'h8888, 5'd1, 5'd2, 5'd3, CTL_A, 1'b0, 1'b0);
    tick();
    checkOutput("release_a", 64'(m_if.a_out), 64'h8888);
    checkOutput("release_ctl", 64'(m_if.ctl_out), 64'h1C1);

    // Hold takes priority over a pending load-use; no bubble, no count
    applyStimulus(1'b1, 32'h5555, 5'd1, 5'd5, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h9999, 5'd5, 5'd6, 5'd7, CTL_R, 1'b1, 1'b0);
    #1 checkOutput("hold_lu_stall", 64'(m_if.stall_out), 64'h1);
    tick();
    checkOutput("hold_lu_valid", 64'(m_if.valid_out), 64'h1);
    checkOutput("hold_lu_ctl", 64'(m_if.ctl_out), 64'h1A1);
    checkOutput("hold_lu_cnt", 64'(m_if.bubble_cnt), 64'(exp_cnt));
    applyStimulus(1'b1, 32'h9999, 5'd5, 5'd6, 5'd7, CTL_R, 1'b0, 1'b0);
    tick();
    exp_cnt++;
    checkOutput("post_hold_bubble", 64'(m_if.valid_out), 64'h0);
    checkOutput("post_hold_cnt", 64'(m_if.bubble_cnt), 64'(exp_cnt));
    tick();
    checkOutput("post_hold_a", 64'(m_if.a_out), 64'h9999);

    // Flush coincident with load-use: flush wins, count unchanged, stall still raised
    applyStimulus(1'b1, 32'h5600, 5'd1, 5'd5, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hF00D, 5'd5, 5'd6, 5'd7, CTL_R, 1'b0, 1'b1);
    #1 checkOutput("flush_lu_stall", 64'(m_if.stall_out), 64'h1);
    tick();
    checkOutput("flush_lu_valid", 64'(m_if.valid_out), 64'h0);
    checkOutput("flush_lu_ctl", 64'(m_if.ctl_out), 64'h0);
    checkOutput("flush_lu_cnt", 64'(m_if.bubble_cnt), 64'(exp_cnt));

    // Plain flush of a valid instruction
    applyStimulus(1'b1, 32'hF00E, 5'd1, 5'd2, 5'd3, CTL_A, 1'b0, 1'b1);
    #1 checkOutput("flush_stall", 64'(m_if.stall_out), 64'h0);
    tick();
    checkOutput("flush_valid", 64'(m_if.valid_out), 64'h0);

    // Drive enough bubbles to saturate the 3-bit counter
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h6000, 5'd1, 5'd5, 5'd0, CTL_LW, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h6001, 5'd5, 5'd0, 5'd7, CTL_R, 1'b0, 1'b0);
      tick();
      exp_cnt++;
    end
    checkOutput("cnt_main", 64'(m_if.bubble_cnt), 64'd9);
    checkOutput("cnt_sat", 64'(s_if.bubble_cnt), 64'd7);
    checkOutput("cnt_sat_valid", 64'(s_if.valid_out), 64'h0);

    // Reset while stalled clears bubble state; next capture is normal
    applyStimulus(1'b1, 32'h6100, 5'd1, 5'd5, 5'd0, CTL_LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h6200, 5'd5, 5'd6, 5'd7, CTL_R, 1'b0, 1'b0);
    #1 checkOutput("mid_stall", 64'(m_if.stall_out), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_stall", 64'(m_if.stall_out), 64'h0);
    checkOutput("mid_rst_cnt", 64'(m_if.bubble_cnt), 64'h0);
    checkOutput("mid_rst_sat_cnt", 64'(s_if.bubble_cnt), 64'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rst_capture_valid", 64'(m_if.valid_out), 64'h1);
    checkOutput("mid_rst_capture_a", 64'(m_if.a_out), 64'h6200);
    checkOutput("mid_rst_capture_ctl", 64'(m_if.ctl_out), 64'h10C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
